mod_cmp_sel_seq: RTL and testbench
==================================

# mod_cmp_sel_seq

Parametrised, multi-cycle successor to the single-cycle modulo/compare/select datapath. It computes z = ((a % c) == zero) ? a − 1 : c + 1 over DATAWIDTH bits. A bit-serial restoring divider replaces the combinational modulo, so wide datapaths close timing. The block sits between operand registers and the result register file, with a start/done handshake toward the controlling sequencer.

## Interface
- DATAWIDTH, 64, operand/result width in bits (≥ 2)
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  DATAWIDTH  dividend / decrement operand (unsigned)
- c  input  DATAWIDTH  divisor / increment operand (unsigned)
- zero  input  DATAWIDTH  compare value for the remainder
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse: z, rem, eq, dbz updated
- z  output  DATAWIDTH  registered selected result
- rem  output  DATAWIDTH  registered remainder a % c
- eq  output  1  registered (rem == zero)
- dbz  output  1  registered divide-by-zero flag for the last operation

## Operation
- States: IDLE, DIV, FIN.
- IDLE: on start=1, latch a, c and zero into internal registers a_q, c_q, zero_q.
  - c ≠ 0: go to DIV. Clear the remainder register r (DATAWIDTH+1 bits). Load shift register q with a. Clear counter cnt.
  - c == 0: go to FIN with r = a_q and dbz_next = 1. By definition, a % 0 = a.
- DIV, per cycle:
  - t = {r[W−1:0], q[W−1]}.
  - If t ≥ c_q, then r = t − c_q; else r = t.
  - q shifts left by one.
  - cnt increments. After the DATAWIDTH-th iteration, go to FIN.
- FIN, one cycle. At its exit edge, load the outputs and return to IDLE:
  - rem = r[W−1:0]
  - eq = (rem == zero_q)
  - z = eq ? a_q − 1 : c_q + 1
  - dbz = dbz_next
  - done = 1
- Arithmetic: unsigned, modulo 2^DATAWIDTH.
  - a_q = 0 decrements to all-ones.
  - c_q = all-ones increments to 0.
  - No carry or borrow outputs.
- busy = (state ≠ IDLE). This is a combinational decode of the state register.
- start while busy is ignored; it is neither queued nor latched.
- Inputs a, c and zero may change freely after the start edge without effect.
- z, rem, eq and dbz hold their values until the next FIN exit.

## Timing
- Reset (Rst=0, asynchronous): state = IDLE. z, rem, eq, dbz, done, busy = 0. Internal registers are cleared.
- Reset mid-operation aborts the operation; no done is produced. Operation resumes on the first edge after Rst is deasserted.
- Let E0 be the edge sampling start=1 in IDLE.
- c ≠ 0:
  - DIV iterations occur at E1…E_W.
  - FIN occupies the cycle after E_W.
  - Outputs load at E_{W+1}, and done is high for the following cycle.
  - Latency is DATAWIDTH+1 edges; for DATAWIDTH=64, that is 65.
- c == 0: FIN follows E0. Outputs load at E1, and done is high for the following cycle. Latency is 1 edge.
- done is registered and never high for two consecutive cycles from a single operation.
- Back-to-back: the state is IDLE during the done cycle, so start=1 in that cycle is accepted. The next done arrives at full latency.
- busy is high from the cycle after E0 through the cycle before done.

## Test plan
- DATAWIDTH=64, a=100, c=7, zero=2, start pulse:
  - busy for 65 cycles.
  - done at E65.
  - rem=2, eq=1, z=99, dbz=0.
- Same operands with zero=0: rem=2, eq=0, z=8. Then change a, c and zero one cycle after start: outputs must be unchanged.
- Divide-by-zero, a=5, c=0, zero=5:
  - done at E1.
  - dbz=1, rem=5, eq=1, z=4.
  - The next normal operation clears dbz.
- Wrap cases, DATAWIDTH=8:
  - a=0, c=255, zero=0: rem=0, eq=1, z=255.
  - a=3, c=255, zero=1: rem=3, eq=0, z=0.
- Rst pulled low 20 cycles into DIV:
  - All outputs drop to 0 immediately.
  - No done.
  - After release, a=9, c=4, zero=1 completes with z=8.
- Contention:
  - start held high throughout an operation: no restart.
  - start=1 in the done cycle with a=10, c=3, zero=2: second done at full latency, rem=1, eq=0, z=4.

Source files
------------

// File: rtl/mod_cmp_sel_seq.sv
// ---------------------------------------------------------------------------
// mod_cmp_sel_seq
//   Multi-cycle modulo / compare / select datapath:
//     z = ((a % c) == zero) ? a - 1 : c + 1   (unsigned, modulo 2^DATAWIDTH)
//   The modulo is computed by a bit-serial restoring divider that retires one
//   dividend bit per clock, so wide datapaths close timing.  a % 0 is defined
//   as a and raises dbz.
//
// Ports
//   Clk    in   rising-edge clock
//   Rst    in   asynchronous active-low reset
//   start  in   operation request, sampled only while idle
//   a      in   dividend / decrement operand
//   c      in   divisor / increment operand
//   zero   in   compare value for the remainder
//   busy   out  operation in flight (state != IDLE)
//   done   out  one-cycle pulse when z/rem/eq/dbz have been updated
//   z      out  registered selected result
//   rem    out  registered remainder a % c
//   eq     out  registered (rem == zero)
//   dbz    out  registered divide-by-zero flag of the last operation
//
// States
//   S_IDLE | waiting for start; operands latched on the accepting edge
//   S_DIV  | one restoring-division iteration per cycle, DATAWIDTH cycles
//   S_FIN  | remainder final; result registers load at the exit edge
// ---------------------------------------------------------------------------
module mod_cmp_sel_seq #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] z,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 eq,
  output logic                 dbz
);

  localparam int W     = DATAWIDTH;
  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     c_q,      c_d;
  logic [W-1:0]     zero_q,   zero_d;
  // The partial remainder is always below the divisor, so it fits in W bits;
  // only the trial value t needs the extra top bit.
  logic [W-1:0]     r_q,      r_d;
  logic [W-1:0]     q_q,      q_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             dbz_nx_q, dbz_nx_d;
  logic [W-1:0]     z_q,      z_d;
  logic [W-1:0]     rem_q,    rem_d;
  logic             eq_q,     eq_d;
  logic             dbz_q,    dbz_d;
  logic             done_q,   done_d;

  logic [W:0]       trial;
  logic [W:0]       trial_sub;
  logic             eq_fin;

  always_comb begin
    trial     = {r_q, q_q[W-1]};
    trial_sub = trial - {1'b0, c_q};
    eq_fin    = (r_q == zero_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    c_d      = c_q;
    zero_d   = zero_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    dbz_nx_d = dbz_nx_q;
    z_d      = z_q;
    rem_d    = rem_q;
    eq_d     = eq_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          c_d    = c;
          zero_d = zero;
          if (c != '0) begin
            state_d  = S_DIV;
            r_d      = '0;
            q_d      = a;
            cnt_d    = '0;
            dbz_nx_d = 1'b0;
          end else begin
            // a % 0 is defined as a; skip the divider entirely.
            state_d  = S_FIN;
            r_d      = a;
            dbz_nx_d = 1'b1;
          end
        end
      end

      S_DIV: begin
        if (trial >= {1'b0, c_q}) begin
          r_d = trial_sub[W-1:0];
        end else begin
          r_d = trial[W-1:0];
        end
        q_d   = q_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        rem_d   = r_q;
        eq_d    = eq_fin;
        z_d     = eq_fin ? (a_q - W'(1)) : (c_q + W'(1));
        dbz_d   = dbz_nx_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      c_q      <= '0;
      zero_q   <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      dbz_nx_q <= 1'b0;
      z_q      <= '0;
      rem_q    <= '0;
      eq_q     <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      c_q      <= c_d;
      zero_q   <= zero_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      dbz_nx_q <= dbz_nx_d;
      z_q      <= z_d;
      rem_q    <= rem_d;
      eq_q     <= eq_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign z    = z_q;
  assign rem  = rem_q;
  assign eq   = eq_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_mod_cmp_sel_seq.sv
module tb_mod_cmp_sel_seq;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic        start64 = 1'b0;
  logic [63:0] a64 = '0, c64 = '0, zin64 = '0;
  logic        busy64, done64, eq64, dbz64;
  logic [63:0] z64, rem64;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, c8 = '0, zin8 = '0;
  logic        busy8, done8, eq8, dbz8;
  logic [7:0]  z8, rem8;

  mod_cmp_sel_seq #(.DATAWIDTH(64)) dut64 (
    .Clk(Clk), .Rst(Rst), .start(start64), .a(a64), .c(c64), .zero(zin64),
    .busy(busy64), .done(done64), .z(z64), .rem(rem64), .eq(eq64), .dbz(dbz64)
  );

  mod_cmp_sel_seq #(.DATAWIDTH(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .start(start8), .a(a8), .c(c8), .zero(zin8),
    .busy(busy8), .done(done8), .z(z8), .rem(rem8), .eq(eq8), .dbz(dbz8)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] z;
    logic [63:0] rem;
    logic        eq;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the arithmetic definition, independent of the divider.
  function automatic exp_t model(input bit w8, input logic [63:0] ta,
                                 input logic [63:0] tc, input logic [63:0] tz);
    exp_t        e;
    logic [63:0] m;
    logic [63:0] r;
    m  = w8 ? 64'h0000_0000_0000_00FF : 64'hFFFF_FFFF_FFFF_FFFF;
    ta = ta & m;
    tc = tc & m;
    tz = tz & m;
    r  = (tc == 64'd0) ? ta : (ta % tc);
    e.rem = r;
    e.eq  = (r == tz);
    e.z   = (e.eq ? (ta - 64'd1) : (tc + 64'd1)) & m;
    e.dbz = (tc == 64'd0);
    e.lat = (tc == 64'd0) ? 1 : (w8 ? 9 : 65);
    return e;
  endfunction

  function automatic logic sel_done(input bit w8);
    return w8 ? done8 : done64;
  endfunction

  function automatic logic sel_busy(input bit w8);
    return w8 ? busy8 : busy64;
  endfunction

  // Called at posedge+1; the next edge is E0.  Returns in the done cycle.
  task automatic run_op(input bit w8, input logic [63:0] ta, input logic [63:0] tc,
                        input logic [63:0] tz, input bit scramble, input bit hold,
                        input string tag);
    exp_t e;
    int   n;
    int   bc;
    logic dn;
    sb.push_back(model(w8, ta, tc, tz));
    if (w8) begin
      a8 = ta[7:0]; c8 = tc[7:0]; zin8 = tz[7:0]; start8 = 1'b1;
    end else begin
      a64 = ta; c64 = tc; zin64 = tz; start64 = 1'b1;
    end
    @(posedge Clk); #1;
    if (!hold) begin
      start8  = 1'b0;
      start64 = 1'b0;
    end
    if (scramble) begin
      a64   = {$urandom, $urandom};
      c64   = {$urandom, $urandom};
      zin64 = {$urandom, $urandom};
      a8    = 8'($urandom);
      c8    = 8'($urandom);
      zin8  = 8'($urandom);
    end
    dn = sel_done(w8);
    chk({tag, "_done_at_e0"}, 64'(dn), 64'd0);
    n  = 0;
    bc = sel_busy(w8) ? 1 : 0;
    while (!dn && n < 300) begin
      @(posedge Clk); #1;
      n++;
      dn = sel_done(w8);
      if (sel_busy(w8)) bc++;
    end
    start8  = 1'b0;
    start64 = 1'b0;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 64'(n), 64'(e.lat));
      chk({tag, "_busy_cycles"}, 64'(bc), 64'(e.lat));
      if (w8) begin
        chk({tag, "_z"},   64'(z8),   e.z);
        chk({tag, "_rem"}, 64'(rem8), e.rem);
        chk({tag, "_eq"},  64'(eq8),  64'(e.eq));
        chk({tag, "_dbz"}, 64'(dbz8), 64'(e.dbz));
      end else begin
        chk({tag, "_z"},   z64,        e.z);
        chk({tag, "_rem"}, rem64,      e.rem);
        chk({tag, "_eq"},  64'(eq64),  64'(e.eq));
        chk({tag, "_dbz"}, 64'(dbz64), 64'(e.dbz));
      end
    end
  endtask

  task automatic idle_after_done(input string tag);
    @(posedge Clk); #1;
    chk({tag, "_done_single"}, 64'(done64 | done8), 64'd0);
    chk({tag, "_idle_busy"},   64'(busy64 | busy8), 64'd0);
  endtask

  initial begin
    int ndone;

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(busy64), 64'd0);
    chk("rst_done", 64'(done64), 64'd0);
    chk("rst_z",    z64,         64'd0);
    chk("rst_rem",  rem64,       64'd0);
    chk("rst_eq",   64'(eq64),   64'd0);
    chk("rst_dbz",  64'(dbz64),  64'd0);
    chk("rst_z8",   64'(z8),     64'd0);
    Rst = 1'b1;
    @(posedge Clk); #1;

    run_op(1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, "basic");
    idle_after_done("basic");

    run_op(1'b0, 64'd100, 64'd7, 64'd0, 1'b0, 1'b0, "zero0");
    idle_after_done("zero0");

    run_op(1'b0, 64'd100, 64'd7, 64'd0, 1'b1, 1'b0, "scramble");
    idle_after_done("scramble");

    run_op(1'b0, 64'd5, 64'd0, 64'd5, 1'b0, 1'b0, "dbz");
    idle_after_done("dbz");

    run_op(1'b0, 64'd100, 64'd7, 64'd0, 1'b0, 1'b0, "dbz_clear");
    idle_after_done("dbz_clear");

    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
           1'b0, 1'b0, "wide_top");
    idle_after_done("wide_top");

    run_op(1'b1, 64'd0, 64'd255, 64'd0, 1'b0, 1'b0, "w8_wrap_dec");
    idle_after_done("w8_wrap_dec");

    run_op(1'b1, 64'd3, 64'd255, 64'd1, 1'b0, 1'b0, "w8_wrap_inc");
    idle_after_done("w8_wrap_inc");

    run_op(1'b1, 64'd200, 64'd13, 64'd5, 1'b0, 1'b0, "w8_div");
    idle_after_done("w8_div");

    run_op(1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 1'b1, "hold");
    idle_after_done("hold");

    run_op(1'b0, 64'd20, 64'd6, 64'd2, 1'b0, 1'b0, "b2b_first");
    run_op(1'b0, 64'd10, 64'd3, 64'd2, 1'b0, 1'b0, "b2b_second");
    idle_after_done("b2b_second");

    a64 = 64'd100; c64 = 64'd7; zin64 = 64'd2; start64 = 1'b1;
    @(posedge Clk); #1;
    start64 = 1'b0;
    repeat (20) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy64), 64'd0);
    chk("abort_done", 64'(done64), 64'd0);
    chk("abort_z",    z64,         64'd0);
    chk("abort_rem",  rem64,       64'd0);
    chk("abort_eq",   64'(eq64),   64'd0);
    chk("abort_dbz",  64'(dbz64),  64'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge Clk); #1;
      if (done64) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    run_op(1'b0, 64'd9, 64'd4, 64'd1, 1'b0, 1'b0, "after_rst");
    idle_after_done("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
